spi_arb2: RTL and testbench

Two-requester arbiter and sequencer in front of the 16-bit SPI master. It accepts a held request and 16-bit command from either of two clients, such as the gyro/inertial reader and the A2D channel poller. It issues one `wrt` pulse per transaction to the master, waits for the master's `done`, and returns the 16-bit read word to the winning client with a one-cycle valid pulse. An enforced idle gap between transactions guarantees SS_n deassert time.

---
 rtl/spi_arb2.sv | 119 +++++++++++
 tb/tb_spi_arb2.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_arb2.sv
// spi_arb2: two-client arbiter/sequencer in front of the 16-bit SPI master.
// Build option: define SPI_ARB_RR_EN for round-robin on contention; otherwise
// req0 has fixed priority and no last-served pointer exists.
module spi_arb2 #(
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] cmd0,
    input  logic [15:0] cmd1,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] resp_data,
    output logic        vld0,
    output logic        vld1,
    output logic        busy
);

    localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t          state, state_d;
    logic            owner, owner_d;
    logic            armed, armed_d;
    logic            win, grant;
    logic            vld0_d, vld1_d;
    logic [15:0]     cmd_d, resp_d;
    logic [GW-1:0]   cnt, cnt_d;

    assign grant = (state == IDLE) && (req0 || req1);

`ifdef SPI_ARB_RR_EN
    logic last;

    // on contention serve whoever was not served last; a lone request always wins
    always_comb win = (req0 && req1) ? ~last : req1;

    // last-served pointer moves only when a grant is made; reset favours req0
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last <= 1'b1;
        else if (grant)
            last <= win;
`else
    // req0 wins whenever it is asserted
    always_comb win = ~req0;
`endif

    // next-state and next-output logic; armed means done was seen low in WAIT,
    // so a done left high from the previous transaction cannot complete this one
    always_comb begin
        state_d = state;
        owner_d = owner;
        cmd_d   = cmd;
        resp_d  = resp_data;
        cnt_d   = cnt;
        vld0_d  = 1'b0;
        vld1_d  = 1'b0;
        armed_d = (state == WAIT) && (armed || !done);
        case (state)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    owner_d = win;
                    cmd_d   = win ? cmd1 : cmd0;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (vld0 || vld1) begin
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    cnt_d   = GW'(GAP_CYCLES);
                end else if (done && armed) begin
                    resp_d = rd_data;
                    vld0_d = ~owner;
                    vld1_d = owner;
                end
            end
            GAP: begin
                cnt_d = cnt - 1'b1;
                if (cnt == GW'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs; wrt and busy are decoded from the next state
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= 1'b0;
            armed     <= 1'b0;
            cnt       <= '0;
            cmd       <= '0;
            resp_data <= '0;
            wrt       <= 1'b0;
            vld0      <= 1'b0;
            vld1      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            owner     <= owner_d;
            armed     <= armed_d;
            cnt       <= cnt_d;
            cmd       <= cmd_d;
            resp_data <= resp_d;
            wrt       <= (state_d == ISSUE);
            vld0      <= vld0_d;
            vld1      <= vld1_d;
            busy      <= (state_d != IDLE);
        end

endmodule

// File: tb/tb_spi_arb2.sv
// tb_spi_arb2: directed scenario bench for spi_arb2 with a simple SPI master model.
module tb_spi_arb2;

    localparam int G   = 2;
    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] cmd0 = 16'h0, cmd1 = 16'h0;
    logic        done;
    logic [15:0] rd_data;
    logic        wrt, vld0, vld1, busy;
    logic [15:0] cmd, resp_data;

    int          errors = 0, checks = 0, cyc = 0;
    int          stale = 0;
    logic [15:0] rsp = 16'h0;
    int          t;
    logic        prev_wrt = 1'b0;
    int          n_wrt = 0, n_v0 = 0, n_v1 = 0, dbl = 0, v0_cyc = 0, v1_cyc = 0;
    logic [15:0] glog[$];
    int          wcyc[$];

    spi_arb2 #(.GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
        .done(done), .rd_data(rd_data), .wrt(wrt), .cmd(cmd), .resp_data(resp_data),
        .vld0(vld0), .vld1(vld1), .busy(busy)
    );

    always #5 clk = ~clk;

    // SPI master: drops done after wrt (optionally 'stale' cycles late), raises it LAT cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0; rd_data <= 16'h0; t <= 0;
        end else if (wrt) begin
            t <= 1;
            if (stale == 0) done <= 1'b0;
        end else if (t != 0) begin
            t <= t + 1;
            if (t >= stale) done <= 1'b0;
            if (t == LAT) begin done <= 1'b1; rd_data <= rsp; t <= 0; end
        end
    end

    task automatic step();
        @(posedge clk); #1; cyc++;
        if (wrt) begin
            if (prev_wrt) dbl++;
            n_wrt++; glog.push_back(cmd); wcyc.push_back(cyc);
        end
        prev_wrt = wrt;
        if (vld0) begin n_v0++; v0_cyc = cyc; end
        if (vld1) begin n_v1++; v1_cyc = cyc; end
    endtask

    task automatic clear_logs();
        glog.delete(); wcyc.delete();
        n_wrt = 0; n_v0 = 0; n_v1 = 0; dbl = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; stale = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        clear_logs();
    endtask

    task automatic wait_vld(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (vld0 || vld1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (wrt !== 1'b0) begin errors++; $display("FAIL rst_wrt: got %b want 0", wrt); end
        checks++; if (cmd !== 16'h0) begin errors++; $display("FAIL rst_cmd: got %h want 0000", cmd); end
        checks++; if (resp_data !== 16'h0) begin errors++; $display("FAIL rst_resp: got %h want 0000", resp_data); end
        checks++; if (vld0 !== 1'b0 || vld1 !== 1'b0) begin errors++; $display("FAIL rst_vld: got %b%b want 00", vld0, vld1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0 || wrt !== 1'b0) begin errors++; $display("FAIL idle_quiet: busy %b wrt %b want 0 0", busy, wrt); end
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        cmd0 = 16'hA5C3; rsp = 16'h1234; req0 = 1'b1;
        step();
        checks++; if (wrt !== 1'b1) begin errors++; $display("FAIL single_wrt: got %b want 1", wrt); end
        checks++; if (cmd !== 16'hA5C3) begin errors++; $display("FAIL single_cmd: got %h want a5c3", cmd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        step();
        checks++; if (wrt !== 1'b0 || cmd !== 16'hA5C3) begin errors++; $display("FAIL single_wrt_pulse: wrt %b cmd %h want 0 a5c3", wrt, cmd); end
        wait_vld(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: no vld within 40 cycles"); end
        checks++; if (vld0 !== 1'b1 || vld1 !== 1'b0) begin errors++; $display("FAIL single_vld: got %b%b want vld0=1 vld1=0", vld0, vld1); end
        checks++; if (resp_data !== 16'h1234) begin errors++; $display("FAIL single_resp: got %h want 1234", resp_data); end
        checks++; if (v0_cyc - wcyc[0] !== 8) begin errors++; $display("FAIL single_latency: got %0d want 8", v0_cyc - wcyc[0]); end
        req0 = 1'b0;
        step();
        checks++; if (vld0 !== 1'b0 || resp_data !== 16'h1234) begin errors++; $display("FAIL single_vld_once: vld0 %b resp %h want 0 1234", vld0, resp_data); end
        repeat (2) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
        repeat (6) step();
        checks++; if (n_wrt !== 1 || n_v1 !== 0) begin errors++; $display("FAIL single_counts: wrt %0d vld1 %0d want 1 0", n_wrt, n_v1); end
    endtask

    task automatic test_contention();
        do_reset();
        cmd0 = 16'h1111; cmd1 = 16'h2222; rsp = 16'h0BAD; req0 = 1'b1; req1 = 1'b1;
`ifdef SPI_ARB_RR_EN
        for (int i = 0; i < 200; i++) begin
            step();
            if (vld0) req0 = 1'b0;
            if (vld1) req1 = 1'b0;
            if (!req0 && !req1 && !busy) break;
        end
        checks++; if (glog.size() !== 2) begin errors++; $display("FAIL rr_grants: got %0d want 2", glog.size()); end
        checks++; if (glog[0] !== 16'h1111) begin errors++; $display("FAIL rr_first: got %h want 1111", glog[0]); end
        checks++; if (glog[1] !== 16'h2222) begin errors++; $display("FAIL rr_second: got %h want 2222", glog[1]); end
        checks++; if (wcyc[1] - v0_cyc !== G + 2) begin errors++; $display("FAIL rr_spacing: got %0d want %0d", wcyc[1] - v0_cyc, G + 2); end
        checks++; if (n_v0 !== 1 || n_v1 !== 1) begin errors++; $display("FAIL rr_vlds: got %0d %0d want 1 1", n_v0, n_v1); end
`else
        for (int i = 0; i < 200; i++) begin
            step();
            if (n_wrt == 3) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (20) step();
        checks++; if (n_wrt !== 3) begin errors++; $display("FAIL fp_grants: got %0d want 3", n_wrt); end
        checks++; if (glog[0] !== 16'h1111 || glog[1] !== 16'h1111 || glog[2] !== 16'h1111) begin
            errors++; $display("FAIL fp_order: got %h %h %h want 1111 x3", glog[0], glog[1], glog[2]); end
        checks++; if (n_v1 !== 0) begin errors++; $display("FAIL fp_starve: vld1 count %0d want 0", n_v1); end
        checks++; if (wcyc[1] - wcyc[0] !== 8 + G + 2) begin errors++; $display("FAIL fp_spacing: got %0d want %0d", wcyc[1] - wcyc[0], 8 + G + 2); end
`endif
        checks++; if (dbl !== 0) begin errors++; $display("FAIL cont_double_wrt: got %0d want 0", dbl); end
    endtask

    task automatic test_stale();
        bit ok;
        do_reset();
        cmd0 = 16'h0001; rsp = 16'h1111; req0 = 1'b1;
        wait_vld(40, ok);
        req0 = 1'b0;
        repeat (6) step();
        clear_logs();
        stale = 3; rsp = 16'hBEEF; cmd1 = 16'h5A5A; req1 = 1'b1;
        step();
        checks++; if (wrt !== 1'b1 || cmd !== 16'h5A5A) begin errors++; $display("FAIL stale_wrt: wrt %b cmd %h want 1 5a5a", wrt, cmd); end
        wait_vld(40, ok);
        req1 = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL stale_timeout: no vld within 40 cycles"); end
        checks++; if (v1_cyc - wcyc[0] !== 8) begin errors++; $display("FAIL stale_latency: got %0d want 8", v1_cyc - wcyc[0]); end
        checks++; if (resp_data !== 16'hBEEF) begin errors++; $display("FAIL stale_resp: got %h want beef", resp_data); end
        repeat (8) step();
        checks++; if (n_v1 !== 1 || n_v0 !== 0) begin errors++; $display("FAIL stale_vlds: got %0d %0d want vld0=0 vld1=1", n_v0, n_v1); end
        stale = 0;
    endtask

    task automatic test_drop();
        bit ok;
        do_reset();
        cmd1 = 16'h3C3C; rsp = 16'h7E7E; req1 = 1'b1;
        step();
        checks++; if (wrt !== 1'b1 || cmd !== 16'h3C3C) begin errors++; $display("FAIL drop_wrt: wrt %b cmd %h want 1 3c3c", wrt, cmd); end
        repeat (3) step();
        req1 = 1'b0;
        wait_vld(40, ok);
        checks++; if (!ok || vld1 !== 1'b1 || vld0 !== 1'b0) begin errors++; $display("FAIL drop_vld: got %b%b want vld1 only", vld0, vld1); end
        checks++; if (resp_data !== 16'h7E7E) begin errors++; $display("FAIL drop_resp: got %h want 7e7e", resp_data); end
        repeat (12) step();
        checks++; if (n_wrt !== 1 || busy !== 1'b0) begin errors++; $display("FAIL drop_regrant: wrt %0d busy %b want 1 0", n_wrt, busy); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        cmd0 = 16'hAAAA; rsp = 16'h5555; req0 = 1'b1;
        step();
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || wrt !== 1'b0) begin errors++; $display("FAIL rstmid_busy: busy %b wrt %b want 0 0", busy, wrt); end
        checks++; if (cmd !== 16'h0) begin errors++; $display("FAIL rstmid_cmd: got %h want 0000", cmd); end
        req0 = 1'b0;
        repeat (10) step();
        checks++; if (n_v0 + n_v1 !== 0) begin errors++; $display("FAIL rstmid_vld: got %0d pulses want 0", n_v0 + n_v1); end
        rst_n = 1'b1; cmd0 = 16'h1357; cmd1 = 16'h2468; req0 = 1'b1; req1 = 1'b1;
        step();
        checks++; if (wrt !== 1'b1 || cmd !== 16'h1357) begin errors++; $display("FAIL rstmid_first: wrt %b cmd %h want 1 1357", wrt, cmd); end
        req0 = 1'b0; req1 = 1'b0;
        repeat (20) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stale();
        test_drop();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
